// File: rtl/uart_pkg.sv
// Shared UART constants, bit-timing helpers and state encodings for uart_rx / uart_tx.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF     = 50_000_000;
  localparam int unsigned BAUD_DEF         = 9600;
  localparam int unsigned CLKS_PER_BIT_DEF = CLK_FREQ_DEF / BAUD_DEF;
  localparam int unsigned HALF_BIT_DEF     = CLKS_PER_BIT_DEF / 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with selectable reset value.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: mid-bit sampling, frame-error detection, sticky avail/overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned BAUD     = BAUD_DEF
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       uart_rxd,
  input  logic       read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_avail,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END   = CW'(HALF_BIT - 1);

  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          avail_q;
  logic          ferr_q;
  logic          ovr_q;
  logic          unread_prev_q;
  logic          rxd_s;
  logic          good_byte;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (clk_50M),
    .rst_i (reset),
    .d_i   (uart_rxd),
    .q_o   (rxd_s)
  );

  assign good_byte = (state_q == RX_STOP) && (cnt_q == BIT_END) && rxd_s;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q       <= RX_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      avail_q       <= 1'b0;
      ferr_q        <= 1'b0;
      ovr_q         <= 1'b0;
      unread_prev_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rxd_s) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_END) begin
            cnt_q   <= '0;
            state_q <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_END) begin
            cnt_q     <= '0;
            shift_q   <= {rxd_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_END) begin
            cnt_q <= '0;
            if (rxd_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= RX_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= RX_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxd_s) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase

      // Overrun is resolved in the rx_valid cycle so a read landing there acknowledges the old byte.
      if (good_byte) begin
        avail_q       <= 1'b1;
        unread_prev_q <= avail_q & ~read;
        if (read) ovr_q <= 1'b0;
      end else if (valid_q) begin
        if (read)               ovr_q <= 1'b0;
        else if (unread_prev_q) ovr_q <= 1'b1;
      end else if (read) begin
        avail_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_avail  = avail_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL derive CLKS_PER_BIT = CLK_FREQ/BAUD (5208 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (2604).
REQ-004 SHALL have port clk_50M  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high, 8N1 LSB-first.
REQ-007 SHALL have port read  input  1  one-cycle pulse acknowledging rx_data; clears rx_avail and overrun.
REQ-008 SHALL have port rx_data  output  8  last correctly framed byte, held until next good byte.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-010 SHALL have port rx_avail  output  1  sticky: unread byte present.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on stop bit sampled low.
REQ-012 SHALL have port overrun  output  1  sticky: good byte completed while rx_avail=1 and read=0.

Function
REQ-013 SHALL pass uart_rxd through a 2-flop synchronizer reset to 1; all decisions use the synchronized value rxd_s.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a single bit-timing counter.
REQ-015 IDLE: on rxd_s=0 (cycle T0) SHALL go to START with counter cleared.
REQ-016 START: at counter=HALF_BIT-1 SHALL sample rxd_s; 1 -> IDLE (false start, no outputs); 0 -> DATA, counter cleared.
REQ-017 DATA: SHALL sample rxd_s at each counter=CLKS_PER_BIT-1 into bit index 0..7 (LSB first), clearing counter; after bit 7 -> STOP.
REQ-018 STOP: at counter=CLKS_PER_BIT-1 SHALL sample rxd_s; 1 -> good byte, IDLE; 0 -> frame_err pulse, rx_data unchanged, WAIT_HIGH.
REQ-019 WAIT_HIGH: SHALL return to IDLE only when rxd_s=1 (break/stuck-low line generates exactly one frame_err).
REQ-020 On good byte SHALL, in the cycle after the stop sample, load rx_data, pulse rx_valid for exactly one cycle, set rx_avail.
REQ-021 Latency: stop sample at T0+HALF_BIT+9*CLKS_PER_BIT; rx_valid at that cycle +1.
REQ-022 Good byte while rx_avail=1 and read=0 SHALL overwrite rx_data and set overrun.
REQ-023 Good byte in same cycle as read SHALL leave rx_avail=1 and SHALL NOT set overrun.
REQ-024 read with rx_avail=0 SHALL have no effect; read never affects the receive state machine.
REQ-025 Counter SHALL be wide enough for CLKS_PER_BIT-1 and never wrap within a bit.

Reset
REQ-026 reset SHALL force state IDLE, counter 0, bit index 0, synchronizer flops 1, rx_data 8'h00, rx_valid 0, rx_avail 0, frame_err 0, overrun 0.
REQ-027 reset asserted mid-frame SHALL abandon the frame with no rx_valid/frame_err; after release, reception restarts at next falling edge of rxd_s.

Structure
REQ-028 CLK_FREQ/BAUD defaults, CLKS_PER_BIT, HALF_BIT and state encodings SHALL live in shared package uart_pkg, also used by uart_tx.
REQ-029 Synchronizer SHALL be a separate sub-module uart_sync (2-flop, parameterized reset value); all else in uart_rx.

Verification
REQ-030 Loopback from uart_tx (write_value 8'h21, 8'h43, 8'h65, default params) -> three rx_valid pulses with rx_data 8'h21, 8'h43, 8'h65, no frame_err.
REQ-031 uart_rxd low pulse of 1 us from idle -> no rx_valid, no frame_err, state back in IDLE.
REQ-032 Frame 8'hA5 with stop bit driven 0 for 2 bit periods then high -> one frame_err pulse, rx_data unchanged, no rx_valid.
REQ-033 Two frames 8'h11, 8'h22 with no read -> overrun=1, rx_data=8'h22; read pulse -> rx_avail=0, overrun=0.
REQ-034 reset asserted during bit 4 of frame 8'h5A, released, then frame 8'h3C -> only rx_data=8'h3C reported.
REQ-035 read asserted in exact rx_valid cycle of a second byte -> rx_avail stays 1, overrun stays 0.
